// File: rtl/ft_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ft_tx_arbiter
// Purpose  : Round-robin arbiter sharing the FT600 TX write channel between
//            N_REQ burst sources. The winner owns the bus for one burst, which
//            ends on its last flag or after MAX_BURST words. Each burst is
//            followed by a GAP_TICKS idle gap.
// Ports    : clk, rst_n           - clock, async active-low reset
//            req                  - per-source burst pending
//            src_data/valid/last  - per-source word stream
//            src_ready            - per-source accept strobe (combinational)
//            grant                - registered one-hot owner (0 = no owner)
//            txe_n                - FT600 FIFO has space when low
//            wr_n, data           - FT600 write strobe (active low) and data
//            burst_done           - one-cycle pulse with the final write
// Revision : 1.0 - initial release
// ============================================================================
module ft_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 256,
  parameter int GAP_TICKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   src_data,
  input  logic [N_REQ-1:0]          src_valid,
  input  logic [N_REQ-1:0]          src_last,
  output logic [N_REQ-1:0]          src_ready,
  output logic [N_REQ-1:0]          grant,
  input  logic                      txe_n,
  output logic                      wr_n,
  output logic [DATA_W-1:0]         data,
  output logic                      burst_done
);

  localparam int c_idx_w = $clog2(N_REQ);
  localparam int c_cnt_w = $clog2(MAX_BURST);
  localparam int c_gap_w = $clog2(GAP_TICKS + 1);
  localparam logic [N_REQ-1:0] c_one = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_rr_ptr;     // last winner; doubles as owner index
  logic [N_REQ-1:0]     r_grant;
  logic [c_cnt_w-1:0]   r_word_cnt;
  logic [c_gap_w-1:0]   r_gap_cnt;
  logic                 r_wr_n;
  logic [DATA_W-1:0]    r_data;
  logic                 r_burst_done;

  logic                 w_found;
  logic [c_idx_w-1:0]   w_pick;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic [DATA_W-1:0]    w_own_data;
  logic                 w_accept;
  logic                 w_end;

  // Round-robin search starting one past the last winner. Scanning from the
  // farthest candidate back to the nearest lets the nearest requester win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[c_idx_w'((int'(r_rr_ptr) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_pick  = c_idx_w'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  // Owner stream mux.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (c_idx_w'(i) == r_rr_ptr) begin
        w_own_valid = src_valid[i];
        w_own_last  = src_last[i];
        w_own_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // txe_n is only looked at here: once accepted, a word is written next cycle.
  assign w_accept = (r_state == S_XFER) && w_own_valid && !txe_n;
  assign w_end    = w_accept && (w_own_last ||
                    (r_word_cnt == c_cnt_w'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    src_ready   = '0;
    if (w_accept) begin
      src_ready = c_one << r_rr_ptr;
    end
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_XFER;
      S_XFER: if (w_end) w_state_nxt = S_GAP;
      S_GAP:  if (r_gap_cnt == c_gap_w'(GAP_TICKS - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= c_idx_w'(N_REQ - 1);
      r_grant      <= '0;
      r_word_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_wr_n       <= 1'b1;
      r_data       <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_wr_n       <= !w_accept;
      r_burst_done <= w_end;
      if (w_accept) begin
        r_data <= w_own_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= c_one << w_pick;
            r_rr_ptr   <= w_pick;
            r_word_cnt <= '0;
          end
        end
        S_XFER: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
          if (w_end) begin
            r_grant   <= '0;
            r_gap_cnt <= '0;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign wr_n       = r_wr_n;
  assign data       = r_data;
  assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_tx_arbiter
// Purpose  : Scoreboard bench for ft_tx_arbiter. Source word queues are loaded
//            per phase; a reference model replays round-robin arbitration over
//            those queues to produce the expected bus write stream, which a
//            monitor compares against every wr_n-low cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 256;
  localparam int GT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, src_valid, src_last, src_ready, grant;
  logic [N*DW-1:0] src_data;
  logic            txe_n, wr_n, burst_done;
  logic [DW-1:0]   data;

  always #5 clk = ~clk;

  ft_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .GAP_TICKS(GT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .grant(grant), .txe_n(txe_n), .wr_n(wr_n), .data(data),
    .burst_done(burst_done)
  );

  typedef struct {
    int         src;
    logic [7:0] d;
    bit         last;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] drv_q[N][$];    // {last, data} per source
  int         checks = 0;
  int         errors = 0;
  int         n_writes = 0;
  int         m_rr = N - 1;
  bit         mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: bursts are taken whole in round-robin order from the sources
  // that still hold words when the arbiter is idle; a burst ends on its last
  // flag or after MB words.
  function automatic void build_expected();
    logic [8:0] mq[N][$];
    int s, cnt;
    bit e_end;
    logic [8:0] w;
    for (int i = 0; i < N; i++) mq[i] = drv_q[i];
    forever begin
      s = -1;
      for (int k = N; k >= 1; k--)
        if (mq[(m_rr + k) % N].size() > 0) s = (m_rr + k) % N;
      if (s < 0) break;
      cnt = 0;
      e_end = 0;
      while (!e_end && mq[s].size() > 0) begin
        w = mq[s].pop_front();
        cnt++;
        e_end = w[8] || (cnt == MB);
        exp_q.push_back('{src: s, d: w[7:0], last: e_end});
      end
      m_rr = s;
    end
  endfunction

  // Monitor: compares every bus write against the scoreboard.
  exp_t e_mon;
  int   idle_run = 0;
  bit   after_burst = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      after_burst = 0;
      idle_run = 0;
    end else if (mon_en) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("src_ready", 32'(src_ready), 32'(grant & src_valid & {N{~txe_n}}));
      if (!wr_n) begin
        n_writes++;
        if (after_burst) chk("gap_ok", 32'(idle_run >= GT + 1), 1);
        after_burst = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("data", 32'(data), 32'(e_mon.d));
          chk("burst_done", 32'(burst_done), 32'(e_mon.last));
          chk("grant_owner", 32'(grant), e_mon.last ? 0 : (1 << e_mon.src));
          if (e_mon.last) begin
            after_burst = 1;
            idle_run = 0;
          end
        end
      end else begin
        chk("burst_done_idle", 32'(burst_done), 0);
        idle_run++;
      end
    end
  end

  task automatic set_idle();
    req = '0;
    src_valid = '0;
    src_last = '0;
    txe_n = 1'b0;
  endtask

  // Drives sources from their queues until the scoreboard drains (or until
  // stop_writes writes were seen). bo_src drops req/valid for 10 cycles
  // after its third accepted word.
  task automatic run_phase(input int vprob, input int tprob, input int bo_src, input int stop_writes);
    logic [N-1:0] rdy;
    int acc[N];
    int bo = 0;
    bit bo_done = 0;
    int cyc = 0;
    int w0 = n_writes;
    int fs = (exp_q.size() > 0) ? exp_q[0].src : -1;
    bit empty;
    for (int i = 0; i < N; i++) acc[i] = 0;
    forever begin
      for (int i = 0; i < N; i++) begin
        if (bo > 0 && i == bo_src) begin
          req[i] = 1'b0;
          src_valid[i] = 1'b0;
        end else begin
          req[i] = (drv_q[i].size() > 0);
          src_valid[i] = req[i] && ($urandom_range(99) < vprob);
        end
        if (drv_q[i].size() > 0) begin
          src_data[i*DW +: DW] = drv_q[i][0][7:0];
          src_last[i] = drv_q[i][0][8];
        end else begin
          src_data[i*DW +: DW] = DW'($urandom);
          src_last[i] = 1'b0;
        end
      end
      txe_n = ($urandom_range(99) < tprob);
      @(negedge clk);
      rdy = src_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && fs >= 0) chk("first_grant", 32'(grant), 1 << fs);
      if (bo > 0) begin
        chk("hold_grant", 32'(grant), 1 << bo_src);
        bo--;
      end
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          void'(drv_q[i].pop_front());
          acc[i]++;
          if (i == bo_src && acc[i] == 3 && !bo_done) begin
            bo = 10;
            bo_done = 1;
          end
        end
      end
      empty = (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) empty = 0;
      if (stop_writes > 0 && (n_writes - w0) >= stop_writes) break;
      if (stop_writes == 0 && empty) break;
      if (cyc > 4000) begin
        chk("phase_timeout", 1, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) drv_q[i].delete();
        break;
      end
    end
    if (stop_writes == 0) begin
      set_idle();
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  task automatic load_burst(input int s, input int len, input int base);
    for (int k = 0; k < len; k++)
      drv_q[s].push_back({(k == len - 1), 8'((base + k) & 8'hff)});
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    src_data = '0;
    src_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_n", 32'(wr_n), 1);
    chk("rst_data", 32'(data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_burst_done", 32'(burst_done), 0);
    chk("rst_src_ready", 32'(src_ready), 0);
    src_valid = '0;
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;

    // Single 5-word burst at full rate.
    load_burst(0, 5, 8'h10);
    build_expected();
    run_phase(100, 0, -1, 0);

    // All sources, two 2-word bursts each.
    for (int i = 0; i < N; i++) begin
      load_burst(i, 2, 8'h20 + 8 * i);
      load_burst(i, 2, 8'h24 + 8 * i);
    end
    build_expected();
    run_phase(100, 0, -1, 0);

    // Source 2 long stream hits the burst cap; others keep competing.
    for (int k = 0; k < 300; k++) drv_q[2].push_back({(k == 299), 8'(k)});
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        load_burst(i, 3, 8'h40 + 16 * i);
        load_burst(i, 3, 8'h48 + 16 * i);
      end
    end
    build_expected();
    run_phase(90, 10, -1, 0);

    // Owner goes quiet mid-burst.
    load_burst(3, 8, 8'h90);
    for (int i = 0; i < 3; i++) load_burst(i, 4, 8'hA0 + 8 * i);
    build_expected();
    run_phase(100, 0, 3, 0);

    // Randomized traffic with stalls.
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < N; i++) begin
        int nb;
        nb = $urandom_range(3);
        for (int b = 0; b < nb; b++) load_burst(i, $urandom_range(1, 8), $urandom_range(255));
      end
      build_expected();
      run_phase($urandom_range(50, 100), $urandom_range(40), -1, 0);
    end

    // Reset in the middle of a burst.
    load_burst(1, 20, 8'h80);
    build_expected();
    run_phase(100, 0, -1, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_n", 32'(wr_n), 1);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_data", 32'(data), 0);
    chk("midrst_burst_done", 32'(burst_done), 0);
    chk("midrst_src_ready", 32'(src_ready), 0);
    set_idle();
    exp_q.delete();
    for (int i = 0; i < N; i++) drv_q[i].delete();
    m_rr = N - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_burst(1, 3, 8'hC0);
    build_expected();
    run_phase(100, 0, -1, 0);
    load_burst(0, 2, 8'hD0);
    load_burst(1, 2, 8'hD8);
    build_expected();
    run_phase(100, 0, -1, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ft_tx_arbiter.md
# ft_tx_arbiter

Round-robin arbiter that shares the FT600 TX write channel (txe_n / wr_n / data) between N_REQ burst sources. Each granted source owns the bus for one whole burst, terminated by its last flag or by MAX_BURST words, followed by a fixed idle gap. Sits between the test-pattern and data-path generators and the FT600 bus pins, replacing direct per-generator drive of wr_n and data.

## Interface
- N_REQ, 4: number of requesters (≥2).
- DATA_W, 8: bus word width.
- MAX_BURST, 256: maximum words per grant (power of two, ≥2).
- GAP_TICKS, 4: idle cycles after each burst (≥1).

- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  source i has a burst pending.
- src_data  in  N_REQ*DATA_W  word of source i in slice [i*DATA_W +: DATA_W].
- src_valid  in  N_REQ  source i word valid.
- src_last  in  N_REQ  source i word is the last of its burst.
- src_ready  out  N_REQ  word of source i accepted this cycle (combinational).
- grant  out  N_REQ  registered one-hot owner; all-zero when no owner.
- txe_n  in  1  FT600 FIFO has space when low.
- wr_n  out  1  FT600 write strobe, active low.
- data  out  DATA_W  FT600 write data.
- burst_done  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, XFER, GAP.
- IDLE: wr_n=1, grant=0. If req≠0: pick first set bit searching from (rr_ptr+1) mod N_REQ upward with wrap; register grant=onehot(g), rr_ptr=g, word_cnt=0; go XFER.
- XFER: src_ready[g] = src_valid[g] & ~txe_n; src_ready of non-owners is 0. On accept: data<=src_data[g], wr_n<=0 next cycle, word_cnt+1. No accept: wr_n<=1, data holds.
- Burst end: accepted word has src_last[g]=1, or word_cnt==MAX_BURST-1 at accept. Go GAP, pulse burst_done, grant<=0 in the same edge.
- req is ignored while in XFER/GAP; dropping req mid-burst does not end it.
- GAP: wr_n=1 after the final written word; count GAP_TICKS cycles, then IDLE.
- word_cnt width $clog2(MAX_BURST), resets to 0 each grant; gap counter width $clog2(GAP_TICKS+1).
- rr_ptr resets to N_REQ-1, so source 0 wins the first arbitration.

## Timing
- Reset (async assert, sync-released use): state=IDLE, wr_n=1, data=0, grant=0, burst_done=0, word_cnt=0, rr_ptr=N_REQ-1. src_ready=0 in reset.
- Reset mid-burst: outputs go to reset values immediately; partial burst is abandoned, no completion pulse.
- req seen in IDLE at edge t → grant valid after t; first possible accept in cycle t+1; first wr_n low cycle t+2.
- Write latency: word accepted in cycle k appears on data with wr_n=0 in cycle k+1 exactly.
- txe_n is sampled only at accept; a word accepted while txe_n=0 is written next cycle even if txe_n rises.
- txe_n high or src_valid low during XFER: stall, wr_n=1, no word lost or duplicated.
- Max throughput: one word per cycle while src_valid and ~txe_n stay asserted.
- burst_done high during the cycle after the final accept (same cycle as the final wr_n=0).
- Minimum bus idle between bursts: GAP_TICKS+1 cycles of wr_n=1 (GAP plus IDLE arbitration cycle).
- src_last and MAX_BURST limit on the same word: single termination, one burst_done.

## Test plan
- Reset then req=4'b0001, source 0 streams 5 words 0x10..0x14 with last on 0x14, txe_n=0 → grant=0001 one cycle later, wr_n low 5 consecutive cycles with data 0x10..0x14, burst_done once, then 4 gap + 1 idle cycles wr_n=1.
- req=4'b1111 held, each source bursts 2 words → grant order 0,1,2,3,0; no overlap of grant bits.
- Source 2 streams without last, MAX_BURST=256 → exactly 256 writes, data matches stream, burst_done on word 256, source 2 re-arbitrated only after others.
- txe_n pulsed high 3 cycles mid-burst → src_ready=0 and wr_n=1 during stall (after one in-flight write), sequence resumes with no gap or duplicate in data.
- rst_n asserted mid-burst after word 7 → wr_n=1, grant=0, data=0 immediately; after release, req=4'b0010 grants source 0 first if requesting, else source 1.
- Owner drops req and src_valid mid-burst for 10 cycles → grant held, wr_n=1, no other source serviced until owner delivers last.
